stage_exe_mdu: RTL and testbench
================================

// Module: stage_exe_mdu
// PURPOSE
//  Parametrised execute stage: ALU path with two-level operand forwarding plus an
//  iterative multiply/divide unit (MDU) owning HI/LO. Sits between ID/EX and EX/MEM.
//  Raises stall to the hazard unit while a MULT/DIV iterates. Emits branch/jump info
//  to stage_if.
// PARAMETERS
//  DATA_W  32  datapath width; also the MDU iteration count
//  REG_AW  5   register-address width
// PORTS
//  clock               in   1       rising-edge clock
//  reset               in   1       async, active-low; clears all state
//  nop_id              in   1       ID/EX slot holds a bubble
//  isJumped            in   1       flush: EX/MEM gets bubble, MDU op aborted
//  data_a, data_b      in   DATA_W  register operands from ID
//  data_imm            in   DATA_W  sign-extended immediate; [5:0] = funct
//  npc                 in   DATA_W  PC+4 of the instruction
//  control_oper        in   4       ALU class to alu_control
//  control_use_b       in   1       0: B = forwarded data_b; 1: B = data_imm
//  control_Reg_DST     in   1       1: dest = regaddr1 (rd); 0: dest = regaddr2 (rt)
//  mdu_op              in   3       0 none,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MFHI,6 MFLO
//  for_a, for_b        in   2       01: result_from_exe; 10: result_from_mem; else regfile
//  result_from_exe/mem in   DATA_W  forwarded values
//  control_is_jump, control_branch_eq, control_branch_inc  in 1 each
//  wbi                 in   2       WB controls; M in 1 memory control
//  regaddr1, regaddr2  in   REG_AW  rd, rt
//  stall               out  1       combinational; hold PC, IF/ID, ID/EX
//  out, data_b_o, jump_address  out DATA_W  registered EX/MEM payload
//  zero, is_jump_o, branch_eq_o, branch_inc_o, M_o, nop  out 1  registered
//  wbi_o out 2; regaddr_o, rt_id out REG_AW  registered
// BEHAVIOUR
//  - Reset (async, reset=0): all registered outputs 0 except nop=1; HI=LO=0; FSM IDLE.
//  - ALU path: A/B forwarding mux as per for_a/for_b (01 has priority order 01, 10,
//    else); jump_address = npc + data_imm (mod 2^DATA_W); zero from ALU.
//  - EX/MEM register: one-cycle latency, updates every clock edge. On isJumped or
//    while stall=1 it loads a bubble (same values as reset, nop=1). Otherwise it
//    captures ALU/MDU result, controls, regaddr_o per control_Reg_DST,
//    rt_id=regaddr2, data_b_o = forwarded B (pre-immediate mux), nop=nop_id.
//  - MFHI/MFLO: out = HI/LO, single cycle, no stall.
//  - MDU FSM IDLE -> BUSY -> DONE -> IDLE:
//    IDLE: mdu_op in 1..4 and !nop_id and !isJumped -> stall=1, latch |A|,|B| (signed
//      ops) or raw operands, record result signs, cnt=DATA_W, go BUSY.
//    BUSY: one shift-add (mul) or restoring-subtract (div) step per cycle; stall=1;
//      cnt-- ; cnt==1 -> DONE.
//    DONE: sign-correct, write HI/LO at edge, stall=0; EX/MEM captures the
//      instruction (wbi/M pass through); -> IDLE.
//    stall high for exactly DATA_W+1 cycles per MULT/DIV.
//  - MULT: {HI,LO} = 2*DATA_W-bit product. DIV: LO = quotient (trunc to 0),
//    HI = remainder (sign of dividend).
//  - Divide by zero: LO = all ones, HI = dividend; same latency, no exception.
//  - Signed most-negative / -1: LO = most-negative, HI = 0 (wrap).
//  - isJumped in BUSY or DONE: abort to IDLE, HI/LO unchanged, stall drops next cycle.
//  - reset mid-operation: immediate IDLE, HI/LO cleared.
//  - MFHI directly after DONE reads the new HI/LO (write precedes read edge).
// TESTING
//  1 ADD, data_a=5, data_b=7, for_a=01, result_from_exe=10 -> next cycle out=17, nop=0.
//  2 MULT A=-3, B=7 -> stall high 33 cycles; then MFLO out=0xFFFFFFEB, MFHI out=0xFFFFFFFF.
//  3 DIVU A=100, B=7 -> LO=14, HI=2; DIV A=-7, B=2 -> LO=-3, HI=-1; DIV by 0 -> LO=0xFFFFFFFF, HI=A.
//  4 DIV A=0x80000000, B=-1 -> LO=0x80000000, HI=0, no hang.
//  5 isJumped at BUSY cycle 10 of MULT -> stall 0 next cycle, HI/LO keep prior values, nop=1.
//  6 reset low mid-DIV -> outputs cleared asynchronously, nop=1; release -> ADD executes normally.

Source files
------------

// File: rtl/stage_exe_mdu.sv
// stage_exe_mdu: execute stage with forwarded ALU path, EX/MEM register and an
// iterative multiply/divide unit that owns HI/LO and stalls the front end while it runs.
module stage_exe_mdu #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              nop_id,
    input  logic              isJumped,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    input  logic [DATA_W-1:0] data_imm,
    input  logic [DATA_W-1:0] npc,
    input  logic [3:0]        control_oper,
    input  logic              control_use_b,
    input  logic              control_Reg_DST,
    input  logic [2:0]        mdu_op,
    input  logic [1:0]        for_a,
    input  logic [1:0]        for_b,
    input  logic [DATA_W-1:0] result_from_exe,
    input  logic [DATA_W-1:0] result_from_mem,
    input  logic              control_is_jump,
    input  logic              control_branch_eq,
    input  logic              control_branch_inc,
    input  logic [1:0]        wbi,
    input  logic              M,
    input  logic [REG_AW-1:0] regaddr1,
    input  logic [REG_AW-1:0] regaddr2,
    output logic              stall,
    output logic [DATA_W-1:0] out,
    output logic [DATA_W-1:0] data_b_o,
    output logic [DATA_W-1:0] jump_address,
    output logic              zero,
    output logic              is_jump_o,
    output logic              branch_eq_o,
    output logic              branch_inc_o,
    output logic              M_o,
    output logic              nop,
    output logic [1:0]        wbi_o,
    output logic [REG_AW-1:0] regaddr_o,
    output logic [REG_AW-1:0] rt_id
);
    localparam int SW = $clog2(DATA_W);
    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [2:0] OP_MULT = 3'd1, OP_DIV = 3'd3, OP_DIVU = 3'd4, OP_MFHI = 3'd5, OP_MFLO = 3'd6;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nx;

    logic [DATA_W-1:0]   op_a, op_b, alu_b, alu_y, mdu_y, abs_a, abs_b;
    logic [DATA_W-1:0]   p_hi, p_lo, dvs, hi, lo, quo_fix, rem_fix;
    logic [2*DATA_W-1:0] prod_fix, mul_step, div_step;
    logic [DATA_W:0]     mul_sum, div_sh, div_df;
    logic [SW-1:0]       shamt;
    logic [CW-1:0]       cnt;
    logic                start, sgn, is_div, neg_q, neg_r, dz;

    assign op_a  = for_a == 2'b01 ? result_from_exe : for_a == 2'b10 ? result_from_mem : data_a;
    assign op_b  = for_b == 2'b01 ? result_from_exe : for_b == 2'b10 ? result_from_mem : data_b;
    assign alu_b = control_use_b ? data_imm : op_b;
    assign shamt = data_imm[6 +: SW];

    always_comb begin
        alu_y = op_a + alu_b;
        case (control_oper)
            4'd1: alu_y = op_a - alu_b;
            4'd2:
                case (data_imm[5:0])
                    6'h22, 6'h23: alu_y = op_a - alu_b;
                    6'h24:        alu_y = op_a & alu_b;
                    6'h25:        alu_y = op_a | alu_b;
                    6'h26:        alu_y = op_a ^ alu_b;
                    6'h27:        alu_y = ~(op_a | alu_b);
                    6'h2A:        alu_y = {{(DATA_W-1){1'b0}}, $signed(op_a) < $signed(alu_b)};
                    6'h2B:        alu_y = {{(DATA_W-1){1'b0}}, op_a < alu_b};
                    6'h00:        alu_y = alu_b << shamt;
                    6'h02:        alu_y = alu_b >> shamt;
                    6'h03:        alu_y = $unsigned($signed(alu_b) >>> shamt);
                    default:      alu_y = op_a + alu_b;
                endcase
            4'd3: alu_y = op_a & alu_b;
            4'd4: alu_y = op_a | alu_b;
            4'd5: alu_y = op_a ^ alu_b;
            4'd6: alu_y = {{(DATA_W-1){1'b0}}, $signed(op_a) < $signed(alu_b)};
            4'd7: alu_y = {{(DATA_W-1){1'b0}}, op_a < alu_b};
            4'd8: alu_y = alu_b << (DATA_W / 2);
            default: alu_y = op_a + alu_b;
        endcase
    end

    assign mdu_y = mdu_op == OP_MFHI ? hi : mdu_op == OP_MFLO ? lo : alu_y;

    // Magnitudes are iterated unsigned; signs are reapplied in DONE.
    assign sgn   = mdu_op == OP_MULT || mdu_op == OP_DIV;
    assign abs_a = (sgn && op_a[DATA_W-1]) ? -op_a : op_a;
    assign abs_b = (sgn && op_b[DATA_W-1]) ? -op_b : op_b;
    assign start = state == IDLE && mdu_op inside {[3'd1:3'd4]} && !nop_id && !isJumped;
    assign stall = start || state == BUSY;

    assign mul_sum  = {1'b0, p_hi} + (p_lo[0] ? {1'b0, dvs} : '0);
    assign mul_step = {mul_sum, p_lo[DATA_W-1:1]};
    assign div_sh   = {p_hi, p_lo[DATA_W-1]};
    assign div_df   = div_sh - {1'b0, dvs};
    assign div_step = div_df[DATA_W] ? {div_sh[DATA_W-1:0], p_lo[DATA_W-2:0], 1'b0}
                                     : {div_df[DATA_W-1:0], p_lo[DATA_W-2:0], 1'b1};
    assign prod_fix = neg_q ? -{p_hi, p_lo} : {p_hi, p_lo};
    assign rem_fix  = neg_r ? -p_hi : p_hi;
    assign quo_fix  = dz ? '1 : neg_q ? -p_lo : p_lo;

    always_comb begin
        state_nx = isJumped ? IDLE :
                   state == IDLE ? (start ? BUSY : IDLE) :
                   state == BUSY ? (cnt == CW'(1) ? DONE : BUSY) : IDLE;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            {p_hi, p_lo, dvs, hi, lo} <= '0;
            {is_div, neg_q, neg_r, dz} <= '0;
            cnt <= '0;
        end else begin
            if (start) begin
                p_hi   <= '0;
                p_lo   <= abs_a;
                dvs    <= abs_b;
                cnt    <= CW'(DATA_W);
                is_div <= mdu_op == OP_DIV || mdu_op == OP_DIVU;
                neg_q  <= sgn && (op_a[DATA_W-1] ^ op_b[DATA_W-1]);
                neg_r  <= sgn && op_a[DATA_W-1];
                dz     <= op_b == '0;
            end else if (state == BUSY) begin
                {p_hi, p_lo} <= is_div ? div_step : mul_step;
                cnt <= cnt - CW'(1);
            end
            if (state == DONE && !isJumped)
                {hi, lo} <= is_div ? {rem_fix, quo_fix} : prod_fix;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            {out, data_b_o, jump_address, zero, is_jump_o, branch_eq_o, branch_inc_o, M_o, wbi_o, regaddr_o, rt_id} <= '0;
            nop <= 1'b1;
        end else if (isJumped || stall) begin
            {out, data_b_o, jump_address, zero, is_jump_o, branch_eq_o, branch_inc_o, M_o, wbi_o, regaddr_o, rt_id} <= '0;
            nop <= 1'b1;
        end else begin
            out          <= mdu_y;
            data_b_o     <= op_b;
            jump_address <= npc + data_imm;
            zero         <= alu_y == '0;
            is_jump_o    <= control_is_jump;
            branch_eq_o  <= control_branch_eq;
            branch_inc_o <= control_branch_inc;
            M_o          <= M;
            wbi_o        <= wbi;
            regaddr_o    <= control_Reg_DST ? regaddr1 : regaddr2;
            rt_id        <= regaddr2;
            nop          <= nop_id;
        end
    end
endmodule

// File: tb/tb_stage_exe_mdu.sv
// tb_stage_exe_mdu: randomized scoreboard bench for stage_exe_mdu against an
// arithmetic reference model of the ALU, forwarding and HI/LO unit.
module tb_stage_exe_mdu;
    logic        clock = 0, reset = 1, nop_id = 1, isJumped = 0;
    logic [31:0] data_a = 0, data_b = 0, data_imm = 0, npc = 0, result_from_exe = 0, result_from_mem = 0;
    logic [3:0]  control_oper = 0;
    logic        control_use_b = 0, control_Reg_DST = 0, control_is_jump = 0, control_branch_eq = 0, control_branch_inc = 0, M = 0;
    logic [2:0]  mdu_op = 0;
    logic [1:0]  for_a = 0, for_b = 0, wbi = 0;
    logic [4:0]  regaddr1 = 0, regaddr2 = 0;
    logic        stall, zero, is_jump_o, branch_eq_o, branch_inc_o, M_o, nop;
    logic [31:0] out, data_b_o, jump_address;
    logic [1:0]  wbi_o;
    logic [4:0]  regaddr_o, rt_id;

    stage_exe_mdu #(.DATA_W(32), .REG_AW(5)) dut (
        .clock(clock), .reset(reset), .nop_id(nop_id), .isJumped(isJumped),
        .data_a(data_a), .data_b(data_b), .data_imm(data_imm), .npc(npc),
        .control_oper(control_oper), .control_use_b(control_use_b), .control_Reg_DST(control_Reg_DST),
        .mdu_op(mdu_op), .for_a(for_a), .for_b(for_b),
        .result_from_exe(result_from_exe), .result_from_mem(result_from_mem),
        .control_is_jump(control_is_jump), .control_branch_eq(control_branch_eq),
        .control_branch_inc(control_branch_inc), .wbi(wbi), .M(M),
        .regaddr1(regaddr1), .regaddr2(regaddr2), .stall(stall), .out(out),
        .data_b_o(data_b_o), .jump_address(jump_address), .zero(zero), .is_jump_o(is_jump_o),
        .branch_eq_o(branch_eq_o), .branch_inc_o(branch_inc_o), .M_o(M_o), .nop(nop),
        .wbi_o(wbi_o), .regaddr_o(regaddr_o), .rt_id(rt_id)
    );

    always #5 clock = ~clock;

    typedef struct { logic [31:0] out, db, ja, ctl; } exp_t;
    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_chk = 0, n_fail = 0;
    logic [31:0] hi_m = 0, lo_m = 0;
    logic [5:0]  funct_list[11] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] alu_m(input logic [3:0] op, input logic [31:0] imm, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(imm[10:6]);
        case (op)
            4'd1: return a - b;
            4'd2:
                case (imm[5:0])
                    6'h22, 6'h23: return a - b;
                    6'h24: return a & b;
                    6'h25: return a | b;
                    6'h26: return a ^ b;
                    6'h27: return ~(a | b);
                    6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h2B: return (a < b) ? 32'd1 : 32'd0;
                    6'h00: return b << sh;
                    6'h02: return b >> sh;
                    6'h03: return $unsigned($signed(b) >>> sh);
                    default: return a + b;
                endcase
            4'd3: return a & b;
            4'd4: return a | b;
            4'd5: return a ^ b;
            4'd6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7: return (a < b) ? 32'd1 : 32'd0;
            4'd8: return {b[15:0], 16'd0};
            default: return a + b;
        endcase
    endfunction

    task automatic mdu_m(input logic [2:0] mop, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        case (mop)
            3'd1: begin p = longint'($signed(a)) * longint'($signed(b)); {hi_m, lo_m} = p; end
            3'd2: begin p = {32'd0, a} * {32'd0, b}; {hi_m, lo_m} = p; end
            3'd3:
                if (b == 0) {hi_m, lo_m} = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) {hi_m, lo_m} = {32'd0, a};
                else begin lo_m = $signed(a) / $signed(b); hi_m = $signed(a) % $signed(b); end
            3'd4:
                if (b == 0) {hi_m, lo_m} = {a, 32'hFFFF_FFFF};
                else begin lo_m = a / b; hi_m = a % b; end
            default: ;
        endcase
    endtask

    task automatic issue(input logic [3:0] oper, input logic [2:0] mop, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [1:0] fa, input logic [1:0] fb, input logic ub,
                         input logic [31:0] exe, input logic [31:0] mem);
        exp_t e;
        logic [31:0] av, bv, alu;
        int n, want;
        @(negedge clock);
        control_oper = oper; mdu_op = mop; data_a = a; data_b = b; data_imm = imm;
        for_a = fa; for_b = fb; control_use_b = ub; result_from_exe = exe; result_from_mem = mem;
        npc = $urandom; regaddr1 = 5'($urandom); regaddr2 = 5'($urandom); control_Reg_DST = 1'($urandom);
        wbi = 2'($urandom); M = 1'($urandom); control_is_jump = 1'($urandom);
        control_branch_eq = 1'($urandom); control_branch_inc = 1'($urandom);
        nop_id = 0; isJumped = 0;
        case (fa) 2'b01: av = exe; 2'b10: av = mem; default: av = a; endcase
        case (fb) 2'b01: bv = exe; 2'b10: bv = mem; default: bv = b; endcase
        alu = alu_m(oper, imm, av, ub ? imm : bv);
        e.out = (mop == 3'd5) ? hi_m : (mop == 3'd6) ? lo_m : alu;
        e.db = bv;
        e.ja = npc + imm;
        e.ctl = {15'd0, alu == 0, control_is_jump, control_branch_eq, control_branch_inc, M, wbi,
                 control_Reg_DST ? regaddr1 : regaddr2, regaddr2};
        exp_q.push_back(e);
        mdu_m(mop, av, bv);
        want = (mop >= 3'd1 && mop <= 3'd4) ? 33 : 0;
        n = 0;
        #1;
        while (stall && n < 100) begin
            n++;
            @(negedge clock);
            #1;
        end
        chk("stall_cycles", n, want);
    endtask

    always @(negedge clock) begin
        if (reset && !nop) begin
            if (exp_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_output actual=%h required=none", out);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out", out, mon_e.out);
                chk("data_b_o", data_b_o, mon_e.db);
                chk("jump_address", jump_address, mon_e.ja);
                chk("ctl", {15'd0, zero, is_jump_o, branch_eq_o, branch_inc_o, M_o, wbi_o, regaddr_o, rt_id}, mon_e.ctl);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a, b, imm;
        logic [3:0]  oper;
        int sel;
        #2 reset = 0;
        #1;
        chk("rst_nop", nop, 1);
        chk("rst_out", out, 0);
        chk("rst_stall", stall, 0);
        chk("rst_ctl", {zero, is_jump_o, branch_eq_o, branch_inc_o, M_o, wbi_o, regaddr_o, rt_id, jump_address[0]}, 0);
        repeat (2) @(negedge clock);
        reset = 1;

        issue(4'd0, 3'd0, 32'd5, 32'd7, 32'd0, 2'b01, 2'b00, 1'b0, 32'd10, $urandom);
        issue(4'd0, 3'd1, 32'hFFFF_FFFD, 32'd7, 32'd0, 2'b00, 2'b00, 1'b0, $urandom, $urandom);
        issue(4'd0, 3'd6, 0, 0, 0, 2'b00, 2'b00, 1'b0, $urandom, $urandom);
        issue(4'd0, 3'd5, 0, 0, 0, 2'b00, 2'b00, 1'b0, $urandom, $urandom);
        issue(4'd0, 3'd4, 32'd100, 32'd7, 0, 2'b00, 2'b00, 1'b0, $urandom, $urandom);
        issue(4'd0, 3'd6, 0, 0, 0, 2'b00, 2'b00, 1'b0, $urandom, $urandom);
        issue(4'd0, 3'd5, 0, 0, 0, 2'b00, 2'b00, 1'b0, $urandom, $urandom);
        issue(4'd0, 3'd3, 32'hFFFF_FFF9, 32'd2, 0, 2'b00, 2'b00, 1'b0, $urandom, $urandom);
        issue(4'd0, 3'd6, 0, 0, 0, 2'b00, 2'b00, 1'b0, $urandom, $urandom);
        issue(4'd0, 3'd5, 0, 0, 0, 2'b00, 2'b00, 1'b0, $urandom, $urandom);
        issue(4'd0, 3'd3, 32'hFFFF_FF85, 32'd0, 0, 2'b00, 2'b00, 1'b0, $urandom, $urandom);
        issue(4'd0, 3'd6, 0, 0, 0, 2'b00, 2'b00, 1'b0, $urandom, $urandom);
        issue(4'd0, 3'd5, 0, 0, 0, 2'b00, 2'b00, 1'b0, $urandom, $urandom);
        issue(4'd0, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 2'b00, 2'b00, 1'b0, $urandom, $urandom);
        issue(4'd0, 3'd6, 0, 0, 0, 2'b00, 2'b00, 1'b0, $urandom, $urandom);
        issue(4'd0, 3'd5, 0, 0, 0, 2'b00, 2'b00, 1'b0, $urandom, $urandom);

        for (int i = 0; i < 40; i++) begin
            oper = 4'($urandom_range(0, 8));
            imm = $urandom;
            if (oper == 4'd2) imm[5:0] = funct_list[$urandom_range(0, 10)];
            issue(oper, 3'd0, $urandom, $urandom, imm, 2'($urandom), 2'($urandom),
                  oper == 4'd2 ? 1'b0 : 1'($urandom), $urandom, $urandom);
        end

        for (int i = 0; i < 12; i++) begin
            a = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            sel = $urandom_range(0, 3);
            b = sel == 0 ? 32'd0 : sel == 1 ? 32'hFFFF_FFFF : sel == 2 ? 32'($urandom_range(1, 20)) : $urandom;
            issue(4'd0, 3'($urandom_range(1, 4)), a, b, $urandom, 2'b00, 2'b00, 1'b0, $urandom, $urandom);
            issue(4'd0, 3'd5, 0, 0, 0, 2'b00, 2'b00, 1'b0, $urandom, $urandom);
            issue(4'd0, 3'd6, 0, 0, 0, 2'b00, 2'b00, 1'b0, $urandom, $urandom);
        end

        // Flush a MULT mid-iteration: HI/LO must keep the previous result.
        @(negedge clock);
        mdu_op = 3'd1; data_a = $urandom; data_b = $urandom; for_a = 0; for_b = 0; nop_id = 0; isJumped = 0;
        repeat (10) @(negedge clock);
        isJumped = 1;
        #1 chk("flush_stall_hold", stall, 1);
        @(negedge clock);
        isJumped = 0; nop_id = 1; mdu_op = 0;
        #1;
        chk("flush_stall", stall, 0);
        chk("flush_nop", nop, 1);
        issue(4'd0, 3'd5, 0, 0, 0, 2'b00, 2'b00, 1'b0, $urandom, $urandom);
        issue(4'd0, 3'd6, 0, 0, 0, 2'b00, 2'b00, 1'b0, $urandom, $urandom);

        // Asynchronous reset in the middle of a DIV.
        issue(4'd0, 3'd2, 32'h0001_2345, 32'h0067_89AB, 0, 2'b00, 2'b00, 1'b0, $urandom, $urandom);
        @(negedge clock);
        mdu_op = 3'd3; data_a = $urandom; data_b = 32'd9; for_a = 0; for_b = 0; nop_id = 0;
        repeat (6) @(negedge clock);
        #2 reset = 0; nop_id = 1; mdu_op = 0;
        #1;
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_nop", nop, 1);
        chk("mid_rst_out", out, 0);
        hi_m = 0; lo_m = 0;
        @(negedge clock);
        reset = 1;
        issue(4'd0, 3'd0, 32'd40, 32'd2, 0, 2'b00, 2'b00, 1'b0, $urandom, $urandom);
        issue(4'd0, 3'd5, 0, 0, 0, 2'b00, 2'b00, 1'b0, $urandom, $urandom);
        issue(4'd0, 3'd6, 0, 0, 0, 2'b00, 2'b00, 1'b0, $urandom, $urandom);

        @(negedge clock);
        nop_id = 1; mdu_op = 0;
        repeat (3) @(negedge clock);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
